// File: rtl/renkon_linebuf_pkg.sv
// Shared constants and FSM encoding for the renkon line buffer.
// Optional overflow flag is enabled by defining RENKON_LINEBUF_OVF_EN.
package renkon_linebuf_pkg;

    localparam int DWIDTH = 16;
    localparam int FSIZE  = 5;
    localparam int MAXW   = 32;
    localparam int LWIDTH = 6;
    localparam int AWIDTH = $clog2(MAXW);
    localparam int WWIDTH = FSIZE * FSIZE * DWIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } lb_state_e;

endpackage

// File: rtl/renkon_linebuf_if.sv
// Pixel-in / window-out bundle between the line buffer and its neighbours.
// buf_err exists only when RENKON_LINEBUF_OVF_EN is defined.
interface renkon_linebuf_if;
    import renkon_linebuf_pkg::*;

    logic                buf_start;
    logic [LWIDTH-1:0]   img_width;
    logic [LWIDTH-1:0]   img_height;
    logic                pixel_en;
    logic [DWIDTH-1:0]   pixel_in;
    logic [WWIDTH-1:0]   window_out;
    logic                window_valid;
    logic                buf_busy;
    logic                buf_done;
`ifdef RENKON_LINEBUF_OVF_EN
    logic                buf_err;
`endif

    modport master (
        output buf_start, img_width, img_height, pixel_en, pixel_in,
`ifdef RENKON_LINEBUF_OVF_EN
        input  buf_err,
`endif
        input  window_out, window_valid, buf_busy, buf_done
    );

    modport slave (
        input  buf_start, img_width, img_height, pixel_en, pixel_in,
`ifdef RENKON_LINEBUF_OVF_EN
        output buf_err,
`endif
        output window_out, window_valid, buf_busy, buf_done
    );

endinterface

// File: rtl/renkon_linebuf_row.sv
// One image line of storage: async read, write on clock, so a read and a
// write to the same column in one cycle returns the old value.
module renkon_linebuf_row
    import renkon_linebuf_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    output logic [DWIDTH-1:0] rdata_o
);

    logic [DWIDTH-1:0] mem_q [MAXW];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/renkon_linebuf.sv
// Line buffer feeding the 5x5 conv stage: FSM, counters, line memories, window.
// Define RENKON_LINEBUF_OVF_EN to add the sticky buf_err flag.
module renkon_linebuf
    import renkon_linebuf_pkg::*;
(
    input  logic            clk,
    input  logic            xrst,
    renkon_linebuf_if.slave bus
);

    lb_state_e         state_q;
    logic [LWIDTH-1:0] row_q, col_q, width_q, height_q;
    logic [DWIDTH-1:0] win_q [FSIZE][FSIZE];
    logic              valid_q, busy_q, done_q;

    logic              in_img, accept, col_last, row_last, at_window;
    logic [DWIDTH-1:0] line_rd [FSIZE-1];
    logic [DWIDTH-1:0] new_col [FSIZE];
    logic [WWIDTH-1:0] win_flat;

    always_comb begin
        in_img    = (state_q == ST_FILL) || (state_q == ST_RUN);
        accept    = in_img && bus.pixel_en && !bus.buf_start;
        col_last  = (col_q == width_q - LWIDTH'(1));
        row_last  = (row_q == height_q - LWIDTH'(1));
        at_window = (row_q >= LWIDTH'(FSIZE-1)) && (col_q >= LWIDTH'(FSIZE-1));
    end

    // Line m holds row-(m+1); oldest line lands in the top window row.
    always_comb begin
        for (int i = 0; i < FSIZE-1; i++) begin
            new_col[i] = line_rd[FSIZE-2-i];
        end
        new_col[FSIZE-1] = bus.pixel_in;
    end

    for (genvar m = 0; m < FSIZE-1; m++) begin : g_line
        logic [DWIDTH-1:0] wdata;
        if (m == 0) begin : g_first
            assign wdata = bus.pixel_in;
        end else begin : g_chain
            assign wdata = line_rd[m-1];
        end
        renkon_linebuf_row u_row (
            .clk     (clk),
            .we_i    (accept),
            .addr_i  (col_q[AWIDTH-1:0]),
            .wdata_i (wdata),
            .rdata_o (line_rd[m])
        );
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (bus.buf_start) begin
                state_q  <= ST_FILL;
                width_q  <= bus.img_width;
                height_q <= bus.img_height;
                row_q    <= '0;
                col_q    <= '0;
                busy_q   <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_FILL, ST_RUN: begin
                        if (accept) begin
                            valid_q <= at_window;
                            if (col_last) begin
                                col_q <= '0;
                                row_q <= row_q + LWIDTH'(1);
                            end else begin
                                col_q <= col_q + LWIDTH'(1);
                            end
                            if (row_last && col_last) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else if (state_q == ST_FILL && row_q == LWIDTH'(FSIZE-1)) begin
                                state_q <= ST_RUN;
                            end
                        end
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            for (int i = 0; i < FSIZE; i++) begin
                for (int j = 0; j < FSIZE; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < FSIZE; i++) begin
                for (int j = 0; j < FSIZE-1; j++) begin
                    win_q[i][j] <= win_q[i][j+1];
                end
                win_q[i][FSIZE-1] <= new_col[i];
            end
        end
    end

    always_comb begin
        win_flat = '0;
        for (int i = 0; i < FSIZE; i++) begin
            for (int j = 0; j < FSIZE; j++) begin
                win_flat[(i*FSIZE+j)*DWIDTH +: DWIDTH] = win_q[i][j];
            end
        end
    end

    assign bus.window_out   = win_flat;
    assign bus.window_valid = valid_q;
    assign bus.buf_busy     = busy_q;
    assign bus.buf_done     = done_q;

`ifdef RENKON_LINEBUF_OVF_EN
    logic err_q;

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            err_q <= 1'b0;
        end else if (bus.buf_start) begin
            err_q <= 1'b0;
        end else if (bus.pixel_en && !in_img) begin
            err_q <= 1'b1;
        end
    end

    assign bus.buf_err = err_q;
`else
    // Stray pixel_en outside an image is dropped without a flag.
`endif

endmodule

// File: tb/tb_renkon_linebuf.sv
// Directed bench for renkon_linebuf; covers the RENKON_LINEBUF_OVF_EN flag
// when that macro is defined.
module tb_renkon_linebuf;
    import renkon_linebuf_pkg::*;

    logic clk  = 1'b0;
    logic xrst = 1'b1;
    always #5 clk = ~clk;

    renkon_linebuf_if bus ();

    renkon_linebuf dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [WWIDTH-1:0] obs, input logic [WWIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Window n of a raster image whose pixel value equals its raster index.
    function automatic logic [WWIDTH-1:0] exp_win(input int w, input int n);
        logic [WWIDTH-1:0] v;
        int r0, c0;
        v  = '0;
        r0 = n / (w - (FSIZE-1));
        c0 = n % (w - (FSIZE-1));
        for (int i = 0; i < FSIZE; i++) begin
            for (int j = 0; j < FSIZE; j++) begin
                v[(i*FSIZE+j)*DWIDTH +: DWIDTH] = DWIDTH'((r0+i)*w + c0 + j);
            end
        end
        return v;
    endfunction

    function automatic int tap(input logic [WWIDTH-1:0] v, input int k);
        return int'(v[k*DWIDTH +: DWIDTH]);
    endfunction

    task automatic start_image(input int w, input int h, input logic stray_en);
        bus.buf_start  = 1'b1;
        bus.img_width  = LWIDTH'(w);
        bus.img_height = LWIDTH'(h);
        bus.pixel_en   = stray_en;
        bus.pixel_in   = 16'hBEEF;
        @(posedge clk); #1;
        bus.buf_start  = 1'b0;
        bus.pixel_en   = 1'b0;
        chki("busy_after_start", int'(bus.buf_busy), 1);
    endtask

    task automatic feed(input int w, input int h, input int npix, input bit toggle, input bit tail,
                        output int nwin, output int ndone,
                        output logic [WWIDTH-1:0] first_win, output logic [WWIDTH-1:0] last_win);
        int p, cyc;
        bit en;
        p = 0; cyc = 0; nwin = 0; ndone = 0;
        first_win = '0; last_win = '0;
        while (p < npix && cyc < 2*npix + 10) begin
            en = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.pixel_en = en;
            bus.pixel_in = DWIDTH'(p);
            @(posedge clk); #1;
            if (bus.window_valid) begin
                if (w >= FSIZE) chkw("window", bus.window_out, exp_win(w, nwin));
                if (nwin == 0) first_win = bus.window_out;
                last_win = bus.window_out;
                nwin++;
            end
            if (toggle) chki("valid_only_after_accept", int'(bus.window_valid && !en), 0);
            if (bus.buf_done) ndone++;
            if (en) begin
                if (p == w*h - 1) begin
                    chki("done_after_last", int'(bus.buf_done), 1);
                    chki("busy_low_in_done", int'(bus.buf_busy), 0);
                end
                p++;
            end
            cyc++;
        end
        bus.pixel_en = 1'b0;
        if (p < npix) chki("feed_timeout", p, npix);
        if (tail) begin
            repeat (3) begin
                @(posedge clk); #1;
                if (bus.window_valid) nwin++;
                if (bus.buf_done) ndone++;
            end
        end
    endtask

    int nwin, ndone;
    logic [WWIDTH-1:0] fw, lw;

    initial begin
        bus.buf_start  = 1'b0;
        bus.img_width  = '0;
        bus.img_height = '0;
        bus.pixel_en   = 1'b0;
        bus.pixel_in   = '0;
        repeat (2) @(posedge clk);
        #1;
        chki("rst_valid", int'(bus.window_valid), 0);
        chki("rst_busy", int'(bus.buf_busy), 0);
        chki("rst_done", int'(bus.buf_done), 0);
        chkw("rst_window", bus.window_out, '0);
`ifdef RENKON_LINEBUF_OVF_EN
        chki("rst_err", int'(bus.buf_err), 0);
`endif
        xrst = 1'b0;
        @(posedge clk); #1;

        // 6x6 continuous, with a stray pixel alongside buf_start
        start_image(6, 6, 1'b1);
        feed(6, 6, 36, 1'b0, 1'b1, nwin, ndone, fw, lw);
        chki("t1_nwin", nwin, 4);
        chki("t1_ndone", ndone, 1);
        chki("t1_first_tap0", tap(fw, 0), 0);
        chki("t1_first_tap24", tap(fw, 24), 28);
        chki("t1_last_tap0", tap(lw, 0), 7);
        chki("t1_last_tap24", tap(lw, 24), 35);
        chki("t1_idle_busy", int'(bus.buf_busy), 0);

        // 6x6 with pixel_en toggling
        start_image(6, 6, 1'b0);
        feed(6, 6, 36, 1'b1, 1'b1, nwin, ndone, fw, lw);
        chki("t2_nwin", nwin, 4);
        chki("t2_ndone", ndone, 1);
        chki("t2_last_tap24", tap(lw, 24), 35);

        // 4 wide, 8 high: narrower than the window
        start_image(4, 8, 1'b0);
        feed(4, 8, 32, 1'b0, 1'b1, nwin, ndone, fw, lw);
        chki("t3_nwin", nwin, 0);
        chki("t3_ndone", ndone, 1);

        // 8x5 aborted after 20 pixels, then a 6x6 image
        start_image(8, 5, 1'b0);
        feed(8, 5, 20, 1'b0, 1'b1, nwin, ndone, fw, lw);
        chki("t4_abort_nwin", nwin, 0);
        chki("t4_abort_ndone", ndone, 0);
        start_image(6, 6, 1'b0);
        feed(6, 6, 36, 1'b0, 1'b1, nwin, ndone, fw, lw);
        chki("t4_nwin", nwin, 4);
        chki("t4_ndone", ndone, 1);
        chki("t4_first_tap0", tap(fw, 0), 0);
        chki("t4_last_tap0", tap(lw, 0), 7);

        // async reset right after a window has been presented
        start_image(6, 6, 1'b0);
        feed(6, 6, 30, 1'b0, 1'b0, nwin, ndone, fw, lw);
        chki("t5_valid_before_rst", int'(bus.window_valid), 1);
        chki("t5_nwin", nwin, 2);
        xrst = 1'b1;
        #1;
        chki("t5_rst_valid", int'(bus.window_valid), 0);
        chki("t5_rst_busy", int'(bus.buf_busy), 0);
        chkw("t5_rst_window", bus.window_out, '0);
        @(posedge clk); #1;
        xrst = 1'b0;
        @(posedge clk); #1;
        start_image(6, 6, 1'b0);
        feed(6, 6, 36, 1'b0, 1'b1, nwin, ndone, fw, lw);
        chki("t5_after_nwin", nwin, 4);
        chki("t5_after_ndone", ndone, 1);

`ifdef RENKON_LINEBUF_OVF_EN
        chki("t6_err_clear", int'(bus.buf_err), 0);
        bus.pixel_en = 1'b1;
        bus.pixel_in = 16'h1234;
        @(posedge clk); #1;
        bus.pixel_en = 1'b0;
        chki("t6_err_set", int'(bus.buf_err), 1);
        repeat (3) @(posedge clk);
        #1;
        chki("t6_err_sticky", int'(bus.buf_err), 1);
        start_image(6, 6, 1'b0);
        chki("t6_err_cleared", int'(bus.buf_err), 0);
        feed(6, 6, 36, 1'b0, 1'b1, nwin, ndone, fw, lw);
        chki("t6_nwin", nwin, 4);
        chki("t6_first_tap24", tap(fw, 24), 28);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
